td4_run_ctrl: RTL
=================

TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  controller can accept a command this cycle.
REQ-006 SHALL have port cmd  input  3  command code: 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 NOP.
REQ-007 SHALL have port cmd_arg  input  4  breakpoint address for SET_BP; ignored otherwise.
REQ-008 SHALL have port div_sel  input  2  tick prescale: 0 every cycle, 1 every 4, 2 every 16, 3 every 256 cycles.
REQ-009 SHALL have port pc  input  4  CPU program counter (address of the next instruction).
REQ-010 SHALL have port cpu_en  output  1  CPU clock-enable; each high cycle retires one instruction.
REQ-011 SHALL have port state  output  2  0 HALT, 1 RUN, 2 STEP, 3 BREAK.
REQ-012 SHALL have port bp_hit  output  1  one-cycle pulse on breakpoint stop.
REQ-013 SHALL have port inst_cnt  output  CNT_W  saturating retired-instruction count.

Function
REQ-014 SHALL accept a command in any cycle where cmd_valid and cmd_ready are both high; commands update registers only and take effect from the next cycle.
REQ-015 SHALL drive cmd_ready low only in STEP; a STEP request thus stalls the next command until the step retires.
REQ-016 SHALL implement an 8-bit prescaler cnt that increments every cycle and wraps to 0 after limit-1 (limit 1/4/16/256); tick = (cnt == limit-1); cnt SHALL clear to 0 on every accepted RUN or STEP.
REQ-017 SHALL compute cpu_en combinationally from registered state, cnt, bp registers and pc only (never from cmd inputs), so a HALT accepted in a tick cycle still lets that tick issue.
REQ-018 SHALL in HALT and BREAK hold cpu_en low; RUN/STEP accepted SHALL move to RUN/STEP; HALT accepted from any state SHALL move to HALT.
REQ-019 SHALL in RUN on tick: if bp_en and pc == bp_addr and skip_bp is low, hold cpu_en low, go to BREAK and pulse bp_hit for that cycle; otherwise assert cpu_en for that cycle.
REQ-020 SHALL in STEP assert cpu_en on the first tick, ignoring the breakpoint, then go to HALT.
REQ-021 SHALL set skip_bp when RUN or STEP is accepted while in BREAK, and clear it after the next issued cpu_en, so execution resumes past the breakpoint instruction.
REQ-022 SHALL on SET_BP load bp_addr = cmd_arg and set bp_en; on CLR_BP clear bp_en; neither changes state.
REQ-023 SHALL increment inst_cnt by 1 on every cpu_en cycle, saturating at all-ones; CLR_CNT SHALL zero it, with CLR_CNT winning over a same-cycle increment.
REQ-024 SHALL treat RUN while in RUN as a prescaler restart only, and STEP while in RUN as a switch to STEP.
REQ-025 SHALL sample div_sel every cycle; a change mid-count SHALL take effect on the next compare, with cnt wrap at 255 as backstop.

Reset
REQ-026 SHALL on rst high set state=HALT, cnt=0, bp_en=0, bp_addr=0, skip_bp=0, inst_cnt=0; cpu_en=0, bp_hit=0 and cmd_ready=1 while rst is high and in the first cycle after.
REQ-027 SHALL make rst override any command presented in the same cycle.

Verification
REQ-028 SHALL cover: reset, div_sel=0, RUN accepted cycle 0 -> state=RUN cycle 1, cpu_en high cycles 1..10, inst_cnt=10 at cycle 11.
REQ-029 SHALL cover: div_sel=1, RUN -> cpu_en high exactly every 4th cycle (cycles 4, 8, 12 after accept).
REQ-030 SHALL cover: SET_BP 5, RUN, pc increments per cpu_en from 0 -> cpu_en for pc 0..4 only, bp_hit one pulse with pc=5, state=BREAK, inst_cnt=5; then RUN -> pc 5 executes, next break at pc 5 only after wrap.
REQ-031 SHALL cover: HALT state, STEP with div_sel=2 -> cmd_ready low, single cpu_en 16 cycles after accept, state=HALT, cmd_ready high.
REQ-032 SHALL cover: inst_cnt preset to 254 in RUN -> saturates at 255; CLR_CNT in a cpu_en cycle -> 0.
REQ-033 SHALL cover: rst asserted mid-RUN together with cmd=STEP -> state=HALT, bp_en=0, no cpu_en next cycle.

Source files
------------

// File: rtl/td4_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | td4_run_ctrl : run/halt/step/breakpoint clock-enable controller for a TD4  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module td4_run_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  input  logic [3:0]       cmd_arg,
  input  logic [1:0]       div_sel,
  input  logic [3:0]       pc,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam logic [2:0] CMD_RUN     = 3'd1;
  localparam logic [2:0] CMD_HALT    = 3'd2;
  localparam logic [2:0] CMD_STEP    = 3'd3;
  localparam logic [2:0] CMD_SET_BP  = 3'd4;
  localparam logic [2:0] CMD_CLR_BP  = 3'd5;
  localparam logic [2:0] CMD_CLR_CNT = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             bp_en_q, bp_en_d;
  logic [3:0]       bp_addr_q, bp_addr_d;
  logic             skip_bp_q, skip_bp_d;
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

  logic [7:0]       lim_m1;
  logic             tick;
  logic             cmd_acc;
  logic             bp_match;

  always_comb begin
    lim_m1 = 8'd0;
    case (div_sel)
      2'd0: lim_m1 = 8'd0;
      2'd1: lim_m1 = 8'd3;
      2'd2: lim_m1 = 8'd15;
      2'd3: lim_m1 = 8'd255;
      default: lim_m1 = 8'd0;
    endcase
  end

  assign tick      = (cnt_q == lim_m1);
  assign cmd_ready = rst || (state_q != ST_STEP);
  assign cmd_acc   = cmd_valid && cmd_ready && !rst;
  assign bp_match  = bp_en_q && (pc == bp_addr_q) && !skip_bp_q;

  // Issue decision uses registered state only, so a same-cycle HALT cannot cancel a tick.
  assign cpu_en = !rst && tick &&
                  (((state_q == ST_RUN) && !bp_match) || (state_q == ST_STEP));
  assign bp_hit = !rst && tick && (state_q == ST_RUN) && bp_match;

  assign state    = state_q;
  assign inst_cnt = inst_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = tick ? 8'd0 : cnt_q + 8'd1;
    bp_en_d    = bp_en_q;
    bp_addr_d  = bp_addr_q;
    skip_bp_d  = skip_bp_q;
    inst_cnt_d = inst_cnt_q;

    if (bp_hit)
      state_d = ST_BREAK;
    else if ((state_q == ST_STEP) && tick)
      state_d = ST_HALT;

    if (cpu_en) begin
      skip_bp_d = 1'b0;
      if (!(&inst_cnt_q))
        inst_cnt_d = inst_cnt_q + CNT_ONE;
    end

    if (cmd_acc) begin
      case (cmd)
        CMD_RUN, CMD_STEP: begin
          state_d = (cmd == CMD_RUN) ? ST_RUN : ST_STEP;
          cnt_d   = 8'd0;
          if (state_q == ST_BREAK)
            skip_bp_d = 1'b1;
        end
        CMD_HALT:    state_d = ST_HALT;
        CMD_SET_BP: begin
          bp_addr_d = cmd_arg;
          bp_en_d   = 1'b1;
        end
        CMD_CLR_BP:  bp_en_d    = 1'b0;
        CMD_CLR_CNT: inst_cnt_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HALT;
      cnt_q      <= 8'd0;
      bp_en_q    <= 1'b0;
      bp_addr_q  <= 4'd0;
      skip_bp_q  <= 1'b0;
      inst_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bp_en_q    <= bp_en_d;
      bp_addr_q  <= bp_addr_d;
      skip_bp_q  <= skip_bp_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

endmodule
`default_nettype wire
